// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Round-robin arbiter that serialises per-core read/write requests onto a
//   single-port RAM, one access every three cycles (IDLE -> ACCESS -> RESP).
//
// Ports
//   clk, reset            system clock; synchronous active-high reset
//   core_req/core_write   per-core request and direction (1 = write)
//   core_addr/core_wdata  per-core address / write data, slice c at [W*c +: W]
//   core_rdata            per-core registered read data (held until next read)
//   core_ack              one-cycle completion pulse, one-hot or zero
//   ram_read/ram_write    RAM strobes, at most one per transaction
//   ram_address/ram_data_in  RAM address and write data
//   ram_data_out          RAM read data, valid the cycle after ram_read
//   busy/grant_id         transaction in flight / core being served

// Per-core read-data holding register.
module ram_port_arbiter_lane #(
  parameter int DATA_LEN = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DATA_LEN-1:0] d,
  output logic [DATA_LEN-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

module ram_port_arbiter #(
  parameter int NO_OF_CORES = 4,
  parameter int ADDRESS_LEN = 12,
  parameter int DATA_LEN    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NO_OF_CORES-1:0]          core_req,
  input  logic [NO_OF_CORES-1:0]          core_write,
  input  logic [ADDRESS_LEN*NO_OF_CORES-1:0] core_addr,
  input  logic [DATA_LEN*NO_OF_CORES-1:0] core_wdata,
  output logic [DATA_LEN*NO_OF_CORES-1:0] core_rdata,
  output logic [NO_OF_CORES-1:0]          core_ack,
  output logic                            ram_read,
  output logic                            ram_write,
  output logic [ADDRESS_LEN-1:0]          ram_address,
  output logic [DATA_LEN-1:0]             ram_data_in,
  input  logic [DATA_LEN-1:0]             ram_data_out,
  output logic                            busy,
  output logic [3:0]                      grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state;
  logic [3:0]             last_grant;
  logic                   wr_q;
  logic                   pick_vld;
  logic [3:0]             pick;
  int                     idx;
  logic [NO_OF_CORES-1:0] sel;
  logic [NO_OF_CORES-1:0] rd_load;

  // Search upward from last_grant+1 with wrap; the first requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int i = 0; i < NO_OF_CORES; i++) begin
      idx = (int'(last_grant) + 1 + i) % NO_OF_CORES;
      if (!pick_vld && core_req[idx]) begin
        pick_vld = 1'b1;
        pick     = 4'(idx);
      end
    end
  end

  // One-hot decode of the served core; read data loads only in RESP of a read.
  always_comb begin
    sel     = '0;
    rd_load = '0;
    for (int c = 0; c < NO_OF_CORES; c++) begin
      sel[c]     = (grant_id == 4'(c));
      rd_load[c] = sel[c] && (state == RESP) && !wr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 4'(NO_OF_CORES - 1);
      wr_q        <= 1'b0;
      core_ack    <= '0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Everything the served core presents is captured here; later
          // changes on its inputs are ignored until the next grant.
          if (pick_vld) begin
            state       <= ACCESS;
            grant_id    <= pick;
            busy        <= 1'b1;
            wr_q        <= core_write[pick];
            ram_write   <= core_write[pick];
            ram_read    <= ~core_write[pick];
            ram_address <= core_addr[ADDRESS_LEN*pick +: ADDRESS_LEN];
            ram_data_in <= core_wdata[DATA_LEN*pick +: DATA_LEN];
          end
        end
        ACCESS: begin
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          core_ack  <= sel;
          state     <= RESP;
        end
        RESP: begin
          // Pointer advances only on a completed (acked) transaction.
          core_ack   <= '0;
          last_grant <= grant_id;
          busy       <= 1'b0;
          grant_id   <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NO_OF_CORES; c++) begin : g_lane
    ram_port_arbiter_lane #(.DATA_LEN(DATA_LEN)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (rd_load[c]),
      .d     (ram_data_out),
      .q     (core_rdata[DATA_LEN*c +: DATA_LEN])
    );
  end

endmodule
